// File: rtl/btn_pkg.sv
// Shared types and constants for the pushbutton debouncer.
// Holds the channel state encoding and the counter sizing helper.
package btn_pkg;

   typedef enum logic {
      STABLE   = 1'b0,
      CHANGING = 1'b1
   } state_t;

   localparam int DB_CYCLES_DEFAULT = 500000;
   localparam int SYNC_STAGES       = 2;

   // Width able to hold DB_CYCLES-1; never narrower than one bit.
   function automatic int cnt_width(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle: raw inputs toward the debouncer, clean outputs back.
// The board/bench side is master, the debouncer is slave.
interface btn_debounce_if #(
   parameter int N_BTN = 2
);

   logic [N_BTN-1:0] BtnIn;
   logic [N_BTN-1:0] BtnLevel;
   logic [N_BTN-1:0] BtnPress;
   logic [N_BTN-1:0] BtnRelease;

   modport master (
      output BtnIn,
      input  BtnLevel,
      input  BtnPress,
      input  BtnRelease
   );

   modport slave (
      input  BtnIn,
      output BtnLevel,
      output BtnPress,
      output BtnRelease
   );

endinterface

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, STABLE/CHANGING FSM,
// persistence counter and registered level/press/release outputs.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic Clk,
   input  logic Rst,
   input  logic btn_in,
   output logic level,
   output logic press,
   output logic rel
);

   localparam int CW = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   state_t                 state;
   state_t                 state_n;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_n;
   logic                   level_n;
   logic                   press_n;
   logic                   rel_n;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) sync <= '0;
      else      sync <= {sync[SYNC_STAGES-2:0], btn_in};
   end

   assign s = sync[SYNC_STAGES-1];

   // State, counter and output registers.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= STABLE;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         level <= level_n;
         press <= press_n;
         rel   <= rel_n;
      end
   end

   // A mismatch must persist DB_CYCLES edges; any match restarts it.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      level_n = level;
      press_n = 1'b0;
      rel_n   = 1'b0;
      unique case (state)
         STABLE: begin
            if (s != level) begin
               state_n = CHANGING;
               cnt_n   = CNT_ONE;
            end else begin
               cnt_n   = '0;
            end
         end
         CHANGING: begin
            if (s == level) begin
               state_n = STABLE;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n = STABLE;
               cnt_n   = '0;
               level_n = s;
               press_n = s;
               rel_n   = ~s;
            end else begin
               cnt_n   = cnt + CNT_ONE;
            end
         end
         default: begin
            state_n = STABLE;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button conditioner: one independent debounce
// channel per input bit, outputs gathered back into the bundle.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int N_BTN     = 2,
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input logic       Clk,
   input logic       Rst,
   btn_debounce_if.slave bus
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DB_CYCLES (DB_CYCLES)
      ) u_ch (
         .Clk    (Clk),
         .Rst    (Rst),
         .btn_in (bus.BtnIn[i]),
         .level  (bus.BtnLevel[i]),
         .press  (bus.BtnPress[i]),
         .rel    (bus.BtnRelease[i])
      );
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with DB_CYCLES=4, N_BTN=2.
// Reference model: per-channel run length of mismatched samples.
module tb_btn_debounce;
   import btn_pkg::*;

   localparam int N  = 2;
   localparam int DB = 4;

   logic Clk = 1'b0;
   logic Rst = 1'b0;

   btn_debounce_if #(.N_BTN(N)) bus ();

   btn_debounce #(
      .N_BTN     (N),
      .DB_CYCLES (DB)
   ) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [N-1:0] p1, p2;
   logic [N-1:0] m_level, m_press, m_rel;
   int           run [N];

   function automatic void model_reset();
      p1 = '0; p2 = '0;
      m_level = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
   endfunction

   // A new value is accepted once it has differed from the
   // level for DB consecutive sampled edges, two edges late.
   function automatic void model_edge(input logic [N-1:0] in);
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < N; i++) begin
         if (p2[i] != m_level[i]) begin
            run[i] = run[i] + 1;
            if (run[i] == DB) begin
               m_level[i] = p2[i];
               m_press[i] = p2[i];
               m_rel[i]   = ~p2[i];
               run[i]     = 0;
            end
         end else begin
            run[i] = 0;
         end
      end
      p2 = p1;
      p1 = in;
   endfunction

   task automatic tick();
      logic [N-1:0] smp;
      smp = bus.BtnIn;
      @(posedge Clk);
      if (!Rst) model_reset();
      else      model_edge(smp);
      #1;
   endtask

   task automatic test_reset();
      bus.BtnIn = 2'b11;
      Rst = 1'b0;
      model_reset();
      #1;
      for (int e = 0; e < 3; e++) begin
         tick();
         n_checks++;
         if ({bus.BtnLevel, bus.BtnPress, bus.BtnRelease} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_hold e=%0d: got %b/%b/%b want 0/0/0",
               e, bus.BtnLevel, bus.BtnPress, bus.BtnRelease);
         end
      end
      Rst = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         n_checks++;
         if ({bus.BtnLevel, bus.BtnPress, bus.BtnRelease} !==
             {m_level, m_press, m_rel}) begin
            n_fail++;
            $display("FAIL reset_model e=%0d: got %b/%b/%b want %b/%b/%b",
               e, bus.BtnLevel, bus.BtnPress, bus.BtnRelease,
               m_level, m_press, m_rel);
         end
         n_checks++;
         if (bus.BtnPress !== ((e == 5) ? 2'b11 : 2'b00)) begin
            n_fail++;
            $display("FAIL reset_press e=%0d: got %b want %b",
               e, bus.BtnPress, (e == 5) ? 2'b11 : 2'b00);
         end
      end
      n_checks++;
      if (bus.BtnLevel !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_level: got %b want 11", bus.BtnLevel);
      end
   endtask

   task automatic test_release();
      bus.BtnIn[0] = 1'b0;
      for (int e = 0; e < 8; e++) begin
         tick();
         n_checks++;
         if ({bus.BtnLevel, bus.BtnPress, bus.BtnRelease} !==
             {m_level, m_press, m_rel}) begin
            n_fail++;
            $display("FAIL release_model e=%0d: got %b/%b/%b want %b/%b/%b",
               e, bus.BtnLevel, bus.BtnPress, bus.BtnRelease,
               m_level, m_press, m_rel);
         end
         n_checks++;
         if (bus.BtnRelease !== ((e == 5) ? 2'b01 : 2'b00) ||
             bus.BtnPress !== 2'b00) begin
            n_fail++;
            $display("FAIL release_strobe e=%0d: got rel=%b prs=%b want rel=%b prs=00",
               e, bus.BtnRelease, bus.BtnPress, (e == 5) ? 2'b01 : 2'b00);
         end
      end
      n_checks++;
      if (bus.BtnLevel !== 2'b10) begin
         n_fail++;
         $display("FAIL release_level: got %b want 10", bus.BtnLevel);
      end
   endtask

   task automatic test_clean_press();
      bus.BtnIn[0] = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         n_checks++;
         if ({bus.BtnLevel, bus.BtnPress, bus.BtnRelease} !==
             {m_level, m_press, m_rel}) begin
            n_fail++;
            $display("FAIL press_model e=%0d: got %b/%b/%b want %b/%b/%b",
               e, bus.BtnLevel, bus.BtnPress, bus.BtnRelease,
               m_level, m_press, m_rel);
         end
         n_checks++;
         if (bus.BtnPress !== ((e == 5) ? 2'b01 : 2'b00) ||
             bus.BtnRelease !== 2'b00 || bus.BtnLevel[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL press_strobe e=%0d: got prs=%b rel=%b lvl=%b want prs=%b rel=00 lvl1=1",
               e, bus.BtnPress, bus.BtnRelease, bus.BtnLevel,
               (e == 5) ? 2'b01 : 2'b00);
         end
      end
   endtask

   task automatic test_bounce();
      int presses;
      bus.BtnIn = 2'b00;
      for (int e = 0; e < 10; e++) begin
         tick();
         n_checks++;
         if ({bus.BtnLevel, bus.BtnPress, bus.BtnRelease} !==
             {m_level, m_press, m_rel}) begin
            n_fail++;
            $display("FAIL bounce_settle e=%0d: got %b/%b/%b want %b/%b/%b",
               e, bus.BtnLevel, bus.BtnPress, bus.BtnRelease,
               m_level, m_press, m_rel);
         end
      end
      presses = 0;
      for (int e = 0; e < 16; e++) begin
         bus.BtnIn[0] = (e < 3) || (e >= 5);
         tick();
         if (bus.BtnPress[0] === 1'b1) presses++;
         n_checks++;
         if ({bus.BtnLevel, bus.BtnPress, bus.BtnRelease} !==
             {m_level, m_press, m_rel}) begin
            n_fail++;
            $display("FAIL bounce_model e=%0d: got %b/%b/%b want %b/%b/%b",
               e, bus.BtnLevel, bus.BtnPress, bus.BtnRelease,
               m_level, m_press, m_rel);
         end
         n_checks++;
         if (bus.BtnPress[0] !== (e == 10) ||
             bus.BtnLevel[0] !== (e >= 10)) begin
            n_fail++;
            $display("FAIL bounce_timing e=%0d: got prs0=%b lvl0=%b want prs0=%b lvl0=%b",
               e, bus.BtnPress[0], bus.BtnLevel[0], e == 10, e >= 10);
         end
      end
      n_checks++;
      if (presses != 1) begin
         n_fail++;
         $display("FAIL bounce_count: got %0d presses want 1", presses);
      end
   endtask

   task automatic test_reset_mid();
      bus.BtnIn = 2'b00;
      for (int e = 0; e < 10; e++) tick();
      n_checks++;
      if (bus.BtnLevel !== 2'b00) begin
         n_fail++;
         $display("FAIL mid_pre: got lvl=%b want 00", bus.BtnLevel);
      end
      bus.BtnIn[1] = 1'b1;
      for (int e = 0; e < 3; e++) tick();
      Rst = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({bus.BtnLevel, bus.BtnPress, bus.BtnRelease} !== 6'b0) begin
         n_fail++;
         $display("FAIL mid_async: got %b/%b/%b want 0/0/0",
            bus.BtnLevel, bus.BtnPress, bus.BtnRelease);
      end
      tick();
      n_checks++;
      if ({bus.BtnLevel, bus.BtnPress, bus.BtnRelease} !== 6'b0) begin
         n_fail++;
         $display("FAIL mid_hold: got %b/%b/%b want 0/0/0",
            bus.BtnLevel, bus.BtnPress, bus.BtnRelease);
      end
      Rst = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         n_checks++;
         if ({bus.BtnLevel, bus.BtnPress, bus.BtnRelease} !==
             {m_level, m_press, m_rel}) begin
            n_fail++;
            $display("FAIL mid_model e=%0d: got %b/%b/%b want %b/%b/%b",
               e, bus.BtnLevel, bus.BtnPress, bus.BtnRelease,
               m_level, m_press, m_rel);
         end
         n_checks++;
         if (bus.BtnLevel[1] !== (e >= 5) || bus.BtnRelease !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_timing e=%0d: got lvl1=%b rel=%b want lvl1=%b rel=00",
               e, bus.BtnLevel[1], bus.BtnRelease, e >= 5);
         end
      end
   endtask

   task automatic test_independent();
      for (int e = 0; e < 10; e++) begin
         if (e == 0) bus.BtnIn[0] = 1'b1;
         if (e == 2) bus.BtnIn[1] = 1'b0;
         tick();
         n_checks++;
         if ({bus.BtnLevel, bus.BtnPress, bus.BtnRelease} !==
             {m_level, m_press, m_rel}) begin
            n_fail++;
            $display("FAIL indep_model e=%0d: got %b/%b/%b want %b/%b/%b",
               e, bus.BtnLevel, bus.BtnPress, bus.BtnRelease,
               m_level, m_press, m_rel);
         end
         n_checks++;
         if (bus.BtnPress !== ((e == 5) ? 2'b01 : 2'b00) ||
             bus.BtnRelease !== ((e == 7) ? 2'b10 : 2'b00)) begin
            n_fail++;
            $display("FAIL indep_strobe e=%0d: got prs=%b rel=%b want prs=%b rel=%b",
               e, bus.BtnPress, bus.BtnRelease,
               (e == 5) ? 2'b01 : 2'b00, (e == 7) ? 2'b10 : 2'b00);
         end
      end
   endtask

   task automatic test_random();
      for (int e = 0; e < 400; e++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 7) == 0) bus.BtnIn[i] = ~bus.BtnIn[i];
         tick();
         n_checks++;
         if ({bus.BtnLevel, bus.BtnPress, bus.BtnRelease} !==
             {m_level, m_press, m_rel}) begin
            n_fail++;
            $display("FAIL random_model e=%0d: got %b/%b/%b want %b/%b/%b",
               e, bus.BtnLevel, bus.BtnPress, bus.BtnRelease,
               m_level, m_press, m_rel);
         end
         n_checks++;
         if ((bus.BtnPress & bus.BtnRelease) !== 2'b00) begin
            n_fail++;
            $display("FAIL random_excl e=%0d: got prs=%b rel=%b want disjoint",
               e, bus.BtnPress, bus.BtnRelease);
         end
      end
   endtask

   initial begin
      bus.BtnIn = '0;
      model_reset();
      test_reset();
      test_release();
      test_clean_press();
      test_bounce();
      test_reset_mid();
      test_independent();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
         n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Multi-channel pushbutton/switch input conditioner for the board-level display designs. It is the input-side counterpart to the counter and seven-segment output path. It synchronises raw, bouncing board inputs and debounces each one. For each channel it delivers a clean level plus single-cycle press and release strobes. These outputs drive enable, direction and count-step controls of the up/down counter.

## Interface
Parameters:
- N_BTN, default 2: number of independent input channels.
- DB_CYCLES, default 500000: consecutive clock edges a new input value must persist before it is accepted. At 50 MHz this is 10 ms. Legal range is 2 or greater.

Ports:
- Clk, input, 1 bit: system clock. The only clock in the block.
- Rst, input, 1 bit: reset. Asynchronous and active-low. All state clears while Rst = 0.
- BtnIn, input, N_BTN bits: raw, asynchronous, bouncing button/switch inputs. Bit i is channel i.
- BtnLevel, output, N_BTN bits: debounced level of each channel. Registered.
- BtnPress, output, N_BTN bits: one-cycle strobe when BtnLevel[i] goes 0→1. Registered.
- BtnRelease, output, N_BTN bits: one-cycle strobe when BtnLevel[i] goes 1→0. Registered.

## Operation
- Channels are fully independent and identical. No cross-channel interaction.
- Per channel, BtnIn[i] passes through a 2-flop synchroniser. The synchroniser reset value is 0. Its output s is the only signal the FSM samples.
- Per-channel FSM has 2 states, STABLE and CHANGING. Each channel also has a counter cnt of width clog2(DB_CYCLES) and the register BtnLevel[i].
  - STABLE, s == BtnLevel: cnt = 0, stay.
  - STABLE, s != BtnLevel: go to CHANGING, cnt ← 1.
  - CHANGING, s == BtnLevel: the bounce is rejected. Go to STABLE, cnt ← 0, no output change.
  - CHANGING, s != BtnLevel, cnt < DB_CYCLES−1: cnt ← cnt+1.
  - CHANGING, s != BtnLevel, cnt == DB_CYCLES−1: accept the change. BtnLevel ← s, cnt ← 0, go to STABLE. Pulse BtnPress if s = 1, or BtnRelease if s = 0.
- Strobes are high for exactly one cycle. BtnPress[i] and BtnRelease[i] are never high together.
- The counter never wraps. It saturates by construction because the accept transition clears it.
- Reset values: sync flops 0, state STABLE, cnt 0, BtnLevel 0, BtnPress 0, BtnRelease 0.
- Inputs already high at reset release are accepted after the normal debounce time. The resulting BtnPress pulse is intended behaviour.

## Timing
- Let edge k be the first clock edge at which the sync flop 1 captures a new BtnIn value that then stays stable.
- s changes after edge k+1.
- BtnLevel and the strobe update on edge k+1+DB_CYCLES. Total latency is DB_CYCLES+2 edges, counting edge k.
- A bounce is any period where s differs from BtnLevel for fewer than DB_CYCLES consecutive edges. A bounce produces no output activity and fully restarts the count.
- Reset asserted mid-count discards the partial count. Outputs drop to 0 asynchronously, with no release strobe. Reset deassertion must be synchronous to Clk; this is handled at top level.
- Continuous presses are limited by debounce only. Two strobes on one channel are at least DB_CYCLES edges apart.

## Structure
- Shared package btn_pkg contains:
  - the state enum {STABLE, CHANGING};
  - constant DB_CYCLES_DEFAULT = 500000;
  - constant SYNC_STAGES = 2;
  - the clog2-based counter-width function.
- One sub-module, btn_debounce_ch, holds one channel's synchroniser, FSM, counter and strobe registers.
- The top level instantiates btn_debounce_ch N_BTN times in a generate loop and concatenates the outputs.

## Test plan
All scenarios use DB_CYCLES = 4 and N_BTN = 2.
- Reset state: hold Rst = 0 with BtnIn = 2'b11. Required: all outputs 0. After release, the BtnLevel 0→1 transitions and single-cycle BtnPress pulses on both bits occur at edge 5.
- Clean press: BtnIn[0] 0→1 before edge 0. Required: BtnLevel[0] = 1 after edge 5. BtnPress[0] = 1 for that one cycle only. BtnRelease stays 0. Channel 1 is untouched.
- Bounce reject: BtnIn[0] = 1 for 3 cycles, 0 for 2 cycles, then 1 steadily. Required: no output change until 4 consecutive mismatched samples after the final rise. Exactly one BtnPress[0].
- Release: starting from BtnLevel[0] = 1, drop BtnIn[0] and hold. Required: BtnLevel[0] = 0 and a BtnRelease[0] pulse 6 edges later. No BtnPress.
- Reset mid-count: raise BtnIn[1], then assert Rst after 3 edges and release it one cycle later. Required: BtnLevel[1] = 0 throughout reset. The count restarts from 0, so BtnLevel[1] rises 6 edges after reset release.
- Independent channels: toggle BtnIn[0] and BtnIn[1] with a 2-cycle offset. Required: strobes appear on each channel 6 edges after its own toggle, 2 cycles apart, with no cross-talk.
